// File: rtl/axi_dw_allocator_pipe.sv
// W-channel allocator: routes W beats from N_TARG_PORT masters to one slave
// port in AW-grant order. A route FIFO holds {port, AWLEN} per granted burst,
// a beat counter regenerates WLAST and flags masters whose own WLAST disagrees,
// and an optional register slice cuts the path toward the slave.
module axi_dw_allocator_pipe #(
  parameter int AXI_DATA_W   = 64,
  parameter int AXI_NUMBYTES = AXI_DATA_W/8,
  parameter int AXI_USER_W   = 6,
  parameter int N_TARG_PORT  = 7,
  parameter int LOG_N_TARG   = $clog2(N_TARG_PORT),
  parameter int FIFO_DEPTH   = 8,
  parameter int OUT_REG      = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 test_en_i,
  input  logic [N_TARG_PORT*AXI_DATA_W-1:0]    wdata_i,
  input  logic [N_TARG_PORT*AXI_NUMBYTES-1:0]  wstrb_i,
  input  logic [N_TARG_PORT-1:0]               wlast_i,
  input  logic [N_TARG_PORT*AXI_USER_W-1:0]    wuser_i,
  input  logic [N_TARG_PORT-1:0]               wvalid_i,
  output logic [N_TARG_PORT-1:0]               wready_o,
  output logic [AXI_DATA_W-1:0]                wdata_o,
  output logic [AXI_NUMBYTES-1:0]              wstrb_o,
  output logic                                 wlast_o,
  output logic [AXI_USER_W-1:0]                wuser_o,
  output logic                                 wvalid_o,
  input  logic                                 wready_i,
  input  logic                                 push_id_i,
  input  logic [LOG_N_TARG-1:0]                id_bin_i,
  input  logic [7:0]                           len_i,
  output logic                                 grant_fifo_id_o,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_count_o,
  output logic                                 wlast_err_o,
  output logic [LOG_N_TARG-1:0]                wlast_err_id_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [LOG_N_TARG-1:0] sel;
    logic [7:0]            len;
  } route_t;

  typedef enum logic {IDLE, BURST} state_e;

  route_t                mem_q [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            beat_q, beat_d;
  state_e                state_q, state_d;
  logic                  err_q, err_d;
  logic [LOG_N_TARG-1:0] err_id_q, err_id_d;

  // Per-port views of the flat master buses
  logic [N_TARG_PORT-1:0][AXI_DATA_W-1:0]   d_arr;
  logic [N_TARG_PORT-1:0][AXI_NUMBYTES-1:0] s_arr;
  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]   u_arr;

  route_t                head;
  logic [LOG_N_TARG-1:0] sel;
  logic                  last, up_rdy, up_vld, acc, push, pop;
  logic                  unused_test;

  assign unused_test = test_en_i;
  assign d_arr = wdata_i;
  assign s_arr = wstrb_i;
  assign u_arr = wuser_i;

  assign head            = mem_q[rd_ptr_q];
  assign sel             = head.sel;
  // Full flag comes from registered count only: a pop in the same cycle
  // never frees a slot for a push.
  assign grant_fifo_id_o = (cnt_q != CW'(FIFO_DEPTH));
  assign fifo_count_o    = cnt_q;
  assign push            = push_id_i & grant_fifo_id_o;
  assign last            = (beat_q == head.len);
  assign up_vld          = (state_q == BURST) & wvalid_i[sel];
  assign acc             = up_vld & up_rdy;
  assign pop             = acc & last;
  assign wlast_err_o     = err_q;
  assign wlast_err_id_o  = err_id_q;

  // Only the active master sees ready; everyone else is stalled
  always_comb begin
    wready_o = '0;
    if (state_q == BURST) wready_o[sel] = up_rdy;
  end

  // Route storage, written on accepted AW grants
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{sel: id_bin_i, len: len_i};
  end

  // FIFO pointers, count, FSM state, beat counter and WLAST error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      beat_q   <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      err_id_q <= err_id_d;
    end
  end

  // Next state: IDLE waits for a route, BURST counts beats to len then pops
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    err_d    = 1'b0;
    err_id_d = err_id_q;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (push) state_d = BURST;
      end
      BURST: begin
        if (acc) begin
          err_d = (wlast_i[sel] != last);
          if (err_d) err_id_d = sel;
          if (last) begin
            beat_d = '0;
            if (cnt_d == '0) state_d = IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  if (OUT_REG != 0) begin : g_reg
    logic                    vld_q;
    logic [AXI_DATA_W-1:0]   data_q;
    logic [AXI_NUMBYTES-1:0] strb_q;
    logic [AXI_USER_W-1:0]   user_q;
    logic                    last_q;

    assign up_rdy = ~vld_q | wready_i;

    // Single-entry slice: loads on every accepted beat, drains on slave ready
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        data_q <= '0;
        strb_q <= '0;
        user_q <= '0;
        last_q <= 1'b0;
      end else if (acc) begin
        vld_q  <= 1'b1;
        data_q <= d_arr[sel];
        strb_q <= s_arr[sel];
        user_q <= u_arr[sel];
        last_q <= last;
      end else if (wready_i) begin
        vld_q  <= 1'b0;
      end
    end

    assign wvalid_o = vld_q;
    assign wdata_o  = data_q;
    assign wstrb_o  = strb_q;
    assign wuser_o  = user_q;
    assign wlast_o  = last_q;
  end else begin : g_comb
    assign up_rdy   = wready_i;
    assign wvalid_o = up_vld;
    assign wdata_o  = d_arr[sel];
    assign wstrb_o  = s_arr[sel];
    assign wuser_o  = u_arr[sel];
    assign wlast_o  = (state_q == BURST) & last;
  end

endmodule

// File: tb/tb_axi_dw_allocator_pipe.sv
// Bench for axi_dw_allocator_pipe: random master traffic, expected slave-side
// beat stream built at AW-push time, checked by an independent monitor.
module tb_axi_dw_allocator_pipe;
  localparam int DW = 64, NB = 8, UW = 6, N = 7, LN = 3, D = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            test_en_i = 1'b0;
  logic [N*DW-1:0] wdata_i;
  logic [N*NB-1:0] wstrb_i;
  logic [N-1:0]    wlast_i, wvalid_i, wready_o;
  logic [N*UW-1:0] wuser_i;
  logic [DW-1:0]   wdata_o;
  logic [NB-1:0]   wstrb_o;
  logic [UW-1:0]   wuser_o;
  logic            wlast_o, wvalid_o, wready_i;
  logic            push_id_i, grant_fifo_id_o, wlast_err_o;
  logic [LN-1:0]   id_bin_i, wlast_err_id_o;
  logic [7:0]      len_i;
  logic [3:0]      fifo_count_o;

  axi_dw_allocator_pipe dut (
    .clk(clk), .rst_n(rst_n), .test_en_i(test_en_i),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wuser_i(wuser_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wuser_o(wuser_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .push_id_i(push_id_i), .id_bin_i(id_bin_i), .len_i(len_i),
    .grant_fifo_id_o(grant_fifo_id_o), .fifo_count_o(fifo_count_o),
    .wlast_err_o(wlast_err_o), .wlast_err_id_o(wlast_err_id_o)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [NB-1:0] s;
    logic [UW-1:0] u;
    logic          l;   // expected slave-side last
    logic          wl;  // WLAST the master drives
  } beat_t;

  beat_t   mq [N][$];   // per-master beats still to be offered
  beat_t   exp_q [$];   // slave-side beats in AW-grant order
  int      n_cmp = 0, n_bad = 0;
  int      pushed_b = 0, done_b = 0, err_pulses = 0, cyc_n = 0;
  int      out_cyc [$];
  bit      rec = 0, hold = 1;
  int      vprob = 100, wr_mode = 0;
  logic [LN-1:0] err_id_seen = '0;

  function automatic void chk(bit ok, string nm, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endfunction

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Master and slave-ready driver: retire handshaken beats, offer the next
  logic [N-1:0] mhs;
  bit           hold_s;
  always begin : drv
    beat_t tmp;
    bit    keep;
    @(negedge clk);
    mhs    = wvalid_i & wready_o;
    hold_s = hold;
    @(posedge clk); #1;
    for (int m = 0; m < N; m++) begin
      keep = 1'b0;
      if (mhs[m] && rst_n && mq[m].size() > 0) tmp = mq[m].pop_front();
      else if (wvalid_i[m]) keep = 1'b1;
      if (!hold_s && mq[m].size() > 0 && (keep || $urandom_range(0, 99) < vprob)) begin
        wvalid_i[m]          = 1'b1;
        wdata_i[m*DW +: DW]  = mq[m][0].d;
        wstrb_i[m*NB +: NB]  = mq[m][0].s;
        wuser_i[m*UW +: UW]  = mq[m][0].u;
        wlast_i[m]           = mq[m][0].wl;
      end else begin
        wvalid_i[m]          = 1'b0;
        wdata_i[m*DW +: DW]  = {$urandom(), $urandom()};
        wstrb_i[m*NB +: NB]  = NB'($urandom());
        wuser_i[m*UW +: UW]  = UW'($urandom());
        wlast_i[m]           = 1'($urandom());
      end
    end
    case (wr_mode)
      0:       wready_i = 1'b1;
      1:       wready_i = ($urandom_range(0, 99) < 70);
      default: wready_i = ~wready_i;
    endcase
  end

  // Monitor: scoreboard pop on every slave handshake, plus per-cycle rules
  beat_t       e;
  bit          prev_stall = 0;
  logic [DW-1:0] prev_d;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      chk($onehot0(wready_o), "wready_onehot0", wready_o, 0);
      if (prev_stall) chk(wvalid_o && wdata_o == prev_d, "stall_stable", wdata_o, prev_d);
      if (wvalid_o && wready_i) begin
        if (exp_q.size() == 0) chk(0, "unexpected_beat", wdata_o, 0);
        else begin
          e = exp_q.pop_front();
          chk(wdata_o == e.d, "wdata", wdata_o, e.d);
          chk(wstrb_o == e.s && wuser_o == e.u, "wstrb_wuser", {wstrb_o, wuser_o}, {e.s, e.u});
          chk(wlast_o == e.l, "wlast", wlast_o, e.l);
          if (e.l) done_b++;
        end
        if (rec) out_cyc.push_back(cyc_n);
      end
      prev_stall = wvalid_o && !wready_i;
      prev_d     = wdata_o;
      if (wlast_err_o) begin
        err_pulses++;
        err_id_seen = wlast_err_id_o;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue an AW grant; when it is expected to be accepted, queue its beats
  task automatic do_push(int id, int len, bit acc, bit bad = 0);
    push_id_i = 1'b1;
    id_bin_i  = id[LN-1:0];
    len_i     = len[7:0];
    if (acc) begin
      for (int k = 0; k <= len; k++) begin
        beat_t b;
        b.d  = {$urandom(), $urandom()};
        b.s  = NB'($urandom());
        b.u  = UW'($urandom());
        b.l  = (k == len);
        b.wl = bad ? (b.l | (k == 0)) : b.l;
        mq[id].push_back(b);
        exp_q.push_back(b);
      end
      pushed_b++;
    end
    @(posedge clk); #1;
    push_id_i = 1'b0;
  endtask

  task automatic drain(string nm);
    int t = 0;
    while (exp_q.size() > 0 && t < 3000) begin
      cyc(1);
      t++;
    end
    chk(exp_q.size() == 0, nm, exp_q.size(), 0);
    cyc(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d0;
    int t, e0;
    push_id_i = 0; id_bin_i = '0; len_i = '0;
    wvalid_i = '0; wdata_i = '0; wstrb_i = '0; wlast_i = '0; wuser_i = '0; wready_i = 1'b1;
    #12;
    chk(wvalid_o == 0 && wready_o == 0, "rst_outputs", {wvalid_o, wready_o}, 0);
    chk(fifo_count_o == 0, "rst_count", fifo_count_o, 0);
    chk(grant_fifo_id_o == 1, "rst_grant", grant_fifo_id_o, 1);
    chk(wlast_err_o == 0 && wlast_err_id_o == 0, "rst_err", {wlast_err_o, wlast_err_id_o}, 0);
    cyc(1); rst_n = 1'b1; cyc(2);

    // 1: single burst, master 2, len 3; latency through the slice
    do_push(2, 3, 1);
    @(negedge clk);
    chk(fifo_count_o == 1, "t1_count1", fifo_count_o, 1);
    chk(wready_o == 7'b0000100, "t1_wready_sel", wready_o, 7'b0000100);
    d0 = mq[2][0].d;
    @(posedge clk); #1; hold = 0;
    t = 0;
    @(negedge clk);
    while (!(wvalid_i[2] && wready_o[2]) && t < 20) begin @(negedge clk); t++; end
    chk(t < 20, "t1_first_hs", t, 0);
    chk(wvalid_o == 0, "t1_no_bypass", wvalid_o, 0);
    @(negedge clk);
    chk(wvalid_o && wdata_o == d0, "t1_latency1", wdata_o, d0);
    @(posedge clk); #1;
    drain("t1_drain");
    chk(fifo_count_o == 0 && wvalid_o == 0, "t1_empty", {fifo_count_o, wvalid_o}, 0);

    // 2: back-to-back bursts 0,5,1 without a bubble
    rec = 1; out_cyc.delete();
    do_push(0, 0, 1); do_push(5, 1, 1); do_push(1, 0, 1);
    drain("t2_drain");
    rec = 0;
    chk(out_cyc.size() == 4, "t2_beats", out_cyc.size(), 4);
    if (out_cyc.size() >= 4) chk(out_cyc[3] - out_cyc[0] == 3, "t2_nobubble", out_cyc[3] - out_cyc[0], 3);

    // 3: fill the route FIFO with traffic held off
    hold = 1;
    for (int i = 0; i < D; i++) do_push($urandom_range(0, N-1), 0, 1);
    @(negedge clk);
    chk(fifo_count_o == 8 && grant_fifo_id_o == 0, "t3_full", {fifo_count_o, grant_fifo_id_o}, {4'd8, 1'b0});
    @(posedge clk); #1;
    do_push(3, 0, 0);
    @(negedge clk);
    chk(fifo_count_o == 8, "t3_ninth_ignored", fifo_count_o, 8);
    @(posedge clk); #1;
    hold = 0; cyc(1); hold = 1;
    do_push(4, 0, 0);            // pop while full: push still refused
    @(negedge clk);
    chk(fifo_count_o == 7, "t3_full_pop_push", fifo_count_o, 7);
    @(posedge clk); #1;
    hold = 0; cyc(1); hold = 1;
    do_push(4, 0, 1);            // pop and push together: count unchanged
    @(negedge clk);
    chk(fifo_count_o == 7, "t3_pushpop_same", fifo_count_o, 7);
    @(posedge clk); #1;
    do_push(6, 0, 1);
    @(negedge clk);
    chk(fifo_count_o == 8 && grant_fifo_id_o == 0, "t3_refill", {fifo_count_o, grant_fifo_id_o}, {4'd8, 1'b0});
    @(posedge clk); #1;
    hold = 0;
    drain("t3_drain");

    // 4: master 3 raises WLAST early
    e0 = err_pulses;
    do_push(3, 1, 1, 1);
    drain("t4_drain");
    chk(err_pulses == e0 + 1, "t4_err_pulse", err_pulses - e0, 1);
    chk(wlast_err_id_o == 3 && err_id_seen == 3, "t4_err_id", wlast_err_id_o, 3);

    // 5: slave ready toggling with several masters queued, then a 256-beat burst
    wr_mode = 2;
    do_push(0, 2, 1); do_push(4, 3, 1); do_push(6, 0, 1); do_push(2, 5, 1); do_push(5, 1, 1);
    drain("t5_drain");
    wr_mode = 0;
    do_push(6, 255, 1);
    drain("t5_len255");

    // Random traffic: random grants, master throttling and slave backpressure
    wr_mode = 1; vprob = 60;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && (pushed_b - done_b) < D)
        do_push($urandom_range(0, N-1), ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 7), 1);
      else
        cyc(1);
    end
    drain("rand_drain");

    // 6: reset in the middle of a burst
    wr_mode = 0; vprob = 100;
    do_push(1, 7, 1);
    cyc(3);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    for (int m = 0; m < N; m++) mq[m].delete();
    pushed_b = done_b;
    #1;
    chk(wvalid_o == 0 && wready_o == 0, "t6_rst_outputs", {wvalid_o, wready_o}, 0);
    chk(fifo_count_o == 0 && grant_fifo_id_o == 1, "t6_rst_fifo", {fifo_count_o, grant_fifo_id_o}, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1);
    do_push(4, 2, 1);
    drain("t6_fresh_burst");
    chk(fifo_count_o == 0, "t6_count0", fifo_count_o, 0);

    chk(err_pulses == 1, "no_spurious_err", err_pulses, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
